biu_multi: RTL and testbench
============================

Name: biu_multi

Overview:
- Parametrised successor to the fixed three-way bus interface unit between the cpu data port and its slaves (dmem, output peripheral, pattern-matching peripheral interface).
- Decodes the CPU data address to one of NSLV slaves and runs a request/ready handshake with per-slave wait states.
- Adds a bus-timeout watchdog, an unmapped-address error response, and sticky error status.
- Sits between cpu and all memory-mapped slaves in the SoC top level and bench.

Parameters:
- NSLV, 4: number of slave ports (1..2**SELW).
- AW, 32: address width.
- DW, 32: data width; byte lanes = DW/8.
- SEL_LSB, 12: lowest address bit of the slave-select field.
- SELW, 3: width of the slave-select field daddr[SEL_LSB +: SELW].
- TIMEOUT, 15: maximum cycles in WAIT before forced error completion (>=1).

Ports:
- clk  in  1  system clock, all state on posedge.
- reset  in  1  synchronous, active-high.
- daddr  in  AW  CPU address.
- dwdata  in  DW  CPU write data.
- dwe  in  DW/8  CPU byte write enables; all zero = read.
- dreq  in  1  CPU access request; held until dready.
- drdata  out  DW  registered read data.
- dready  out  1  one-cycle completion pulse.
- derr  out  1  qualifies dready: access failed.
- s_daddr  out  AW  latched address, shared by all slaves.
- s_dwdata  out  DW  latched write data, shared.
- s_sel  out  NSLV  one-hot slave select.
- s_dwe  out  NSLV*DW/8  byte enables; slave k uses bits [k*DW/8 +: DW/8].
- s_drdata  in  NSLV*DW  slave read data; slave k uses [k*DW +: DW].
- s_ready  in  NSLV  slave completion; sampled only when selected.
- err_addr  out  AW  address of most recent failed access (sticky).
- err_cnt  out  8  failed-access count, saturating.

Behaviour:
- Reset: state=IDLE. drdata=0, dready=0, derr=0, s_sel=0, s_dwe=0, s_daddr=0, s_dwdata=0, err_addr=0, err_cnt=0, timeout counter=0.
- States: IDLE, WAIT, UNMAP, RESP.
- IDLE:
  - When dreq=1, latch daddr, dwdata and dwe, and compute idx = daddr[SEL_LSB +: SELW].
  - idx < NSLV: go to WAIT. From the next cycle, s_sel[idx]=1 and s_dwe lane group idx = latched dwe; all other lanes are 0.
  - idx >= NSLV: go to UNMAP. No s_sel is asserted.
- WAIT:
  - s_sel and s_dwe are held stable. s_dwe stays asserted for the whole WAIT period; slaves must tolerate repeated writes or act on the first cycle.
  - If s_ready[idx]=1: capture s_drdata slice idx into drdata, set derr=0, go to RESP.
  - Otherwise increment the counter. When counter == TIMEOUT-1 and s_ready is still 0: drdata=32'hDEAD_BEEF (truncated or zero-extended to DW), derr=1, go to RESP.
  - s_sel/s_dwe drop on leaving WAIT.
- UNMAP: one cycle. drdata=32'hDEAD_BEEF, derr=1, go to RESP.
- RESP:
  - dready=1 for exactly this cycle; derr is valid here.
  - On error: err_addr <= latched address; err_cnt increments and saturates at 255.
  - Clear the counter and return to IDLE.
- Latency, dreq rising to dready:
  - Mapped access with slave ready on its first WAIT cycle: 2 cycles.
  - Unmapped access: 2 cycles.
  - Timeout: TIMEOUT+1 cycles.
- Outside RESP, dready=0 and derr=0. drdata holds its last value until the next RESP.
- Changes on daddr/dwdata/dwe/dreq after acceptance are ignored until RESP.
- dreq still high in the RESP cycle is not a new request. A new access is accepted no earlier than the first IDLE cycle after RESP.
- s_ready on unselected slaves, and s_ready outside WAIT, are ignored.
- Reset asserted in any state: the next cycle is IDLE with all outputs at reset values. An in-flight access is dropped with no dready and no error count.

Test Plan:
1. Read from slave 1 (daddr=32'h0000_1004, dwe=0), s_ready[1]=1 immediately, s_drdata slice 1=32'h1234_5678 -> s_sel=4'b0010 for 1 cycle; dready with derr=0 and drdata=32'h1234_5678 2 cycles after dreq.
2. Byte write to slave 2 (daddr=32'h0000_2000, dwe=4'b0010), s_ready[2] delayed 3 cycles -> s_dwe=16'h0200 throughout WAIT; dready 5 cycles after dreq with derr=0.
3. Unmapped access (daddr=32'h0000_5000) -> no s_sel; dready+derr at cycle 2; drdata=32'hDEAD_BEEF, err_addr=32'h0000_5000, err_cnt=1.
4. Slave 0 never ready, TIMEOUT=15 -> s_sel[0] high 15 cycles; dready+derr at cycle 16; err_cnt increments.
5. 300 consecutive unmapped accesses -> err_cnt saturates at 255. Reset pulse mid-WAIT -> s_sel=0 next cycle, no dready, err_cnt=0.
6. Back-to-back mapped accesses with dreq held high -> second acceptance one cycle after RESP; the two captured drdata values differ and are correct.

Source files
------------

// File: rtl/biu_multi_if.sv
// ---------------------------------------------------------------------------
// biu_multi_if: bus bundle between the CPU data port, the BIU and the
// memory-mapped slaves.
//
//   CPU side   : daddr, dwdata, dwe, dreq   (CPU -> BIU)
//                drdata, dready, derr       (BIU -> CPU)
//   Slave side : s_daddr, s_dwdata, s_sel, s_dwe (BIU -> slaves)
//                s_drdata, s_ready               (slaves -> BIU)
//
// Modports:
//   master : the CPU data port
//   slave  : the BIU (slave of the CPU, owner of the slave-side bus)
//   periph : the collection of memory-mapped slaves
// ---------------------------------------------------------------------------
interface biu_multi_if #(
    parameter int NSLV = 4,
    parameter int AW   = 32,
    parameter int DW   = 32
);
    localparam int BW = DW / 8;

    logic [AW-1:0]      daddr;
    logic [DW-1:0]      dwdata;
    logic [BW-1:0]      dwe;
    logic               dreq;
    logic [DW-1:0]      drdata;
    logic               dready;
    logic               derr;

    logic [AW-1:0]      s_daddr;
    logic [DW-1:0]      s_dwdata;
    logic [NSLV-1:0]    s_sel;
    logic [NSLV*BW-1:0] s_dwe;
    logic [NSLV*DW-1:0] s_drdata;
    logic [NSLV-1:0]    s_ready;

    modport master (
        output daddr, dwdata, dwe, dreq,
        input  drdata, dready, derr
    );

    modport slave (
        input  daddr, dwdata, dwe, dreq,
        output drdata, dready, derr,
        output s_daddr, s_dwdata, s_sel, s_dwe,
        input  s_drdata, s_ready
    );

    modport periph (
        input  s_daddr, s_dwdata, s_sel, s_dwe,
        output s_drdata, s_ready
    );
endinterface

// File: rtl/biu_multi.sv
// ---------------------------------------------------------------------------
// biu_multi: bus interface unit between the CPU data port and NSLV
// memory-mapped slaves.
//
// The slave is picked by daddr[SEL_LSB +: SELW]. A mapped access holds the
// one-hot select and byte enables for the whole WAIT period until the slave
// answers with s_ready or the watchdog expires after TIMEOUT cycles. Unmapped
// addresses and timeouts complete with derr=1 and a DEAD_BEEF data pattern,
// and are logged in err_addr / err_cnt (saturating).
//
// Ports:
//   clk      : system clock, all state on posedge
//   reset    : synchronous, active-high
//   bus      : biu_multi_if.slave (CPU handshake + shared slave bus)
//   err_addr : address of the most recent failed access (sticky)
//   err_cnt  : failed-access count, saturates at 255
// ---------------------------------------------------------------------------
module biu_multi #(
    parameter int NSLV    = 4,
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int SEL_LSB = 12,
    parameter int SELW    = 3,
    parameter int TIMEOUT = 15
) (
    input  logic          clk,
    input  logic          reset,
    biu_multi_if.slave    bus,
    output logic [AW-1:0] err_addr,
    output logic [7:0]    err_cnt
);
    localparam int BW = DW / 8;
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0]   CNT_LAST = CW'(TIMEOUT - 1);
    localparam logic [SELW:0]   NSLV_W   = (SELW + 1)'(NSLV);
    localparam logic [DW-1:0]   ERR_DATA = DW'(32'hDEAD_BEEF);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_UNMAP,
        ST_RESP
    } state_t;

    state_t             state_q, state_d;
    logic [AW-1:0]      addr_q, addr_d;
    logic [DW-1:0]      wdata_q, wdata_d;
    logic [NSLV-1:0]    sel_q, sel_d;
    logic [NSLV*BW-1:0] s_dwe_q, s_dwe_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [DW-1:0]      drdata_q, drdata_d;
    logic               dready_q, dready_d;
    logic               derr_q, derr_d;
    logic [AW-1:0]      err_addr_q, err_addr_d;
    logic [7:0]         err_cnt_q, err_cnt_d;

    // Address decode of the live CPU request (used only on acceptance)
    logic [SELW-1:0]    idx;
    logic               mapped;
    logic [NSLV-1:0]    dec_sel;
    logic [NSLV*BW-1:0] dec_dwe;

    // Read-data mux driven by the registered select, so only the slave that
    // owns the access can contribute data or completion.
    logic [DW-1:0]      rd_masked [NSLV];
    logic [DW-1:0]      rdata_mux;
    logic               ready_hit;

    assign idx    = bus.daddr[SEL_LSB +: SELW];
    assign mapped = ({1'b0, idx} < NSLV_W);

    genvar gi;
    generate
        for (gi = 0; gi < NSLV; gi++) begin : g_slv
            assign dec_sel[gi]            = (idx == SELW'(gi));
            assign dec_dwe[gi*BW +: BW]   = dec_sel[gi] ? bus.dwe : '0;
            assign rd_masked[gi]          = sel_q[gi] ? bus.s_drdata[gi*DW +: DW] : '0;
        end
    endgenerate

    always_comb begin
        rdata_mux = '0;
        for (int k = 0; k < NSLV; k++) begin
            rdata_mux = rdata_mux | rd_masked[k];
        end
    end

    assign ready_hit = |(bus.s_ready & sel_q);

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        sel_d      = sel_q;
        s_dwe_d    = s_dwe_q;
        cnt_d      = cnt_q;
        drdata_d   = drdata_q;
        dready_d   = 1'b0;
        derr_d     = 1'b0;
        err_addr_d = err_addr_q;
        err_cnt_d  = err_cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.dreq) begin
                    addr_d  = bus.daddr;
                    wdata_d = bus.dwdata;
                    cnt_d   = '0;
                    if (mapped) begin
                        state_d = ST_WAIT;
                        sel_d   = dec_sel;
                        s_dwe_d = dec_dwe;
                    end else begin
                        state_d = ST_UNMAP;
                    end
                end
            end
            ST_WAIT: begin
                if (ready_hit) begin
                    drdata_d = rdata_mux;
                    dready_d = 1'b1;
                    state_d  = ST_RESP;
                    sel_d    = '0;
                    s_dwe_d  = '0;
                end else if (cnt_q == CNT_LAST) begin
                    // Watchdog: this was the TIMEOUT-th cycle without an answer
                    drdata_d = ERR_DATA;
                    dready_d = 1'b1;
                    derr_d   = 1'b1;
                    state_d  = ST_RESP;
                    sel_d    = '0;
                    s_dwe_d  = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_UNMAP: begin
                drdata_d = ERR_DATA;
                dready_d = 1'b1;
                derr_d   = 1'b1;
                state_d  = ST_RESP;
            end
            ST_RESP: begin
                // derr_q is the error flag being presented this cycle
                if (derr_q) begin
                    err_addr_d = addr_q;
                    if (err_cnt_q != 8'hFF) begin
                        err_cnt_d = err_cnt_q + 8'd1;
                    end
                end
                cnt_d   = '0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            wdata_q    <= '0;
            sel_q      <= '0;
            s_dwe_q    <= '0;
            cnt_q      <= '0;
            drdata_q   <= '0;
            dready_q   <= 1'b0;
            derr_q     <= 1'b0;
            err_addr_q <= '0;
            err_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            sel_q      <= sel_d;
            s_dwe_q    <= s_dwe_d;
            cnt_q      <= cnt_d;
            drdata_q   <= drdata_d;
            dready_q   <= dready_d;
            derr_q     <= derr_d;
            err_addr_q <= err_addr_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    assign bus.drdata   = drdata_q;
    assign bus.dready   = dready_q;
    assign bus.derr     = derr_q;
    assign bus.s_daddr  = addr_q;
    assign bus.s_dwdata = wdata_q;
    assign bus.s_sel    = sel_q;
    assign bus.s_dwe    = s_dwe_q;
    assign err_addr     = err_addr_q;
    assign err_cnt      = err_cnt_q;
endmodule

// File: tb/tb_biu_multi.sv
// ---------------------------------------------------------------------------
// tb_biu_multi: directed self-checking bench for biu_multi (NSLV=4, AW=DW=32,
// SEL_LSB=12, SELW=3, TIMEOUT=15). Slaves are modelled by driving s_ready /
// s_drdata directly; unselected slaves keep s_ready high to show it is
// ignored.
// ---------------------------------------------------------------------------
module tb_biu_multi;
    logic        clk;
    logic        reset;
    logic [31:0] err_addr;
    logic [7:0]  err_cnt;

    int n_chk  = 0;
    int n_fail = 0;

    biu_multi_if #(.NSLV(4), .AW(32), .DW(32)) bus ();

    biu_multi #(
        .NSLV(4), .AW(32), .DW(32), .SEL_LSB(12), .SELW(3), .TIMEOUT(15)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .bus     (bus),
        .err_addr(err_addr),
        .err_cnt (err_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Runs one access. Returns latency in cycles (0 = no dready within bound),
    // the number of cycles any s_sel was high, the number of selected cycles
    // with wrong s_sel/s_dwe/s_daddr/s_dwdata, and the completion data/error.
    task automatic access(input logic [31:0] a, input logic [3:0] we, input logic [31:0] wd,
                          input int rdy_at, input logic [3:0] exp_sel, input logic [15:0] exp_dwe,
                          input bit keep, output int lat, output int sel_cyc, output int bad,
                          output logic [31:0] rd, output logic er);
        bus.daddr  = a;
        bus.dwdata = wd;
        bus.dwe    = we;
        bus.dreq   = 1'b1;
        lat = 0; sel_cyc = 0; bad = 0; rd = '0; er = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            tick();
            if (bus.dready) begin
                lat = c;
                rd  = bus.drdata;
                er  = bus.derr;
                break;
            end
            if (bus.s_sel != 4'b0) begin
                sel_cyc++;
                if (bus.s_sel !== exp_sel || bus.s_dwe !== exp_dwe ||
                    bus.s_daddr !== a || bus.s_dwdata !== wd) bad++;
                // accepted: scramble the CPU side, it must be ignored now
                bus.daddr  = ~a;
                bus.dwdata = ~wd;
                bus.dwe    = ~we;
            end
            bus.s_ready = (((rdy_at > 0) && (c >= rdy_at)) ? exp_sel : 4'b0) | ~exp_sel;
        end
        if (!keep) bus.dreq = 1'b0;
        bus.s_ready = 4'b0;
        $display("txn addr=%h we=%h lat=%0d sel_cycles=%0d derr=%0b rdata=%h",
                 a, we, lat, sel_cyc, er, rd);
    endtask

    int          lat, sc, bad, nerr, nrdy;
    logic [31:0] rd, rd1;
    logic        er;

    initial begin
        reset        = 1'b1;
        bus.daddr    = '0;
        bus.dwdata   = '0;
        bus.dwe      = '0;
        bus.dreq     = 1'b0;
        bus.s_ready  = '0;
        bus.s_drdata = {32'h3333_3333, 32'h5555_2222, 32'h1234_5678, 32'hAAAA_0000};
        tick();
        tick();
        reset = 1'b0;

        // Reset state
        chk("rst_drdata", bus.drdata, 0);
        chk("rst_dready", bus.dready, 0);
        chk("rst_derr", bus.derr, 0);
        chk("rst_s_sel", bus.s_sel, 0);
        chk("rst_s_dwe", bus.s_dwe, 0);
        chk("rst_s_daddr", bus.s_daddr, 0);
        chk("rst_s_dwdata", bus.s_dwdata, 0);
        chk("rst_err_addr", err_addr, 0);
        chk("rst_err_cnt", err_cnt, 0);
        tick();

        // 1: read slave 1, ready on first WAIT cycle
        access(32'h0000_1004, 4'b0000, 32'h0, 1, 4'b0010, 16'h0000, 1'b0, lat, sc, bad, rd, er);
        chk("t1_lat", lat, 2);
        chk("t1_sel_cycles", sc, 1);
        chk("t1_bus_bad", bad, 0);
        chk("t1_derr", er, 0);
        chk("t1_drdata", rd, 32'h1234_5678);
        tick();
        chk("t1_dready_pulse", bus.dready, 0);
        chk("t1_drdata_hold", bus.drdata, 32'h1234_5678);

        // 2: byte write to slave 2, ready after 3 wait cycles
        access(32'h0000_2000, 4'b0010, 32'hA5A5_0F0F, 4, 4'b0100, 16'h0200, 1'b0, lat, sc, bad, rd, er);
        chk("t2_lat", lat, 5);
        chk("t2_sel_cycles", sc, 4);
        chk("t2_bus_bad", bad, 0);
        chk("t2_derr", er, 0);
        chk("t2_drdata", rd, 32'h5555_2222);
        tick();

        // 3: unmapped address
        access(32'h0000_5000, 4'b0000, 32'h0, 0, 4'b0000, 16'h0000, 1'b0, lat, sc, bad, rd, er);
        chk("t3_lat", lat, 2);
        chk("t3_sel_cycles", sc, 0);
        chk("t3_derr", er, 1);
        chk("t3_drdata", rd, 32'hDEAD_BEEF);
        tick();
        chk("t3_err_addr", err_addr, 32'h0000_5000);
        chk("t3_err_cnt", err_cnt, 1);
        chk("t3_derr_idle", bus.derr, 0);

        // 4: slave 0 never ready -> watchdog
        access(32'h0000_0010, 4'b0000, 32'h0, 0, 4'b0001, 16'h0000, 1'b0, lat, sc, bad, rd, er);
        chk("t4_lat", lat, 16);
        chk("t4_sel_cycles", sc, 15);
        chk("t4_bus_bad", bad, 0);
        chk("t4_derr", er, 1);
        chk("t4_drdata", rd, 32'hDEAD_BEEF);
        tick();
        chk("t4_err_cnt", err_cnt, 2);
        chk("t4_err_addr", err_addr, 32'h0000_0010);

        // 5a: 300 unmapped accesses -> err_cnt saturates
        nerr = 0;
        for (int i = 0; i < 300; i++) begin
            access(32'h0000_7000 + 32'(i), 4'b0000, 32'h0, 0, 4'b0000, 16'h0000, 1'b0,
                   lat, sc, bad, rd, er);
            if (lat != 0 && er) nerr++;
        end
        chk("t5_err_completions", nerr, 300);
        tick();
        chk("t5_err_cnt_sat", err_cnt, 255);
        chk("t5_err_addr_last", err_addr, 32'h0000_7000 + 32'd299);

        // 5b: reset pulse in the middle of WAIT
        bus.daddr   = 32'h0000_0020;
        bus.dwe     = 4'b1111;
        bus.dreq    = 1'b1;
        bus.s_ready = 4'b0000;
        tick();
        chk("t5_sel_in_wait", bus.s_sel, 4'b0001);
        tick();
        reset    = 1'b1;
        bus.dreq = 1'b0;
        tick();
        reset = 1'b0;
        chk("t5_rst_s_sel", bus.s_sel, 0);
        chk("t5_rst_s_dwe", bus.s_dwe, 0);
        chk("t5_rst_dready", bus.dready, 0);
        chk("t5_rst_err_cnt", err_cnt, 0);
        chk("t5_rst_err_addr", err_addr, 0);
        chk("t5_rst_drdata", bus.drdata, 0);
        nrdy = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (bus.dready || bus.s_sel != 4'b0) nrdy++;
        end
        chk("t5_no_late_activity", nrdy, 0);
        chk("t5_err_cnt_after", err_cnt, 0);

        // 6: back-to-back with dreq held high through RESP
        bus.s_drdata = {32'hCAFE_0003, 32'h5555_2222, 32'h1234_5678, 32'h0BAD_F00D};
        access(32'h0000_3008, 4'b0000, 32'h0, 1, 4'b1000, 16'h0000, 1'b1, lat, sc, bad, rd1, er);
        chk("t6a_lat", lat, 2);
        chk("t6a_drdata", rd1, 32'hCAFE_0003);
        chk("t6a_derr", er, 0);
        access(32'h0000_0004, 4'b0000, 32'h0, 2, 4'b0001, 16'h0000, 1'b0, lat, sc, bad, rd, er);
        chk("t6b_lat", lat, 3);
        chk("t6b_sel_cycles", sc, 1);
        chk("t6b_bus_bad", bad, 0);
        chk("t6b_drdata", rd, 32'h0BAD_F00D);
        chk("t6_values_differ", (rd != rd1), 1);
        tick();
        chk("t6_err_cnt", err_cnt, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
